uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_bit_timer.sv | 28 ++
 rtl/uart_tx.sv | 103 ++++++++++
 tb/tb_uart_tx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states and line levels, common to the tx and rx paths.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

  localparam int unsigned DATA_BITS   = 8;
  localparam logic        IDLE_LEVEL  = 1'b1;
  localparam logic        START_LEVEL = 1'b0;

endpackage : uart_pkg

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts CLK cycles within a bit and pulses bit_done in the last one.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic bit_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  // Wraps to zero at every bit boundary so consecutive bits share one counter.
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == CNT_LAST) ? '0 : count + CNT_W'(1);
    end
  end

  assign bit_done = enable && (count == CNT_LAST);

endmodule : uart_bit_timer

// File: rtl/uart_tx.sv
// 8N1-style UART transmitter for the FTB1 line: valid/ready byte in, LSB-first serial out.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DATA,
  input  logic       VALID,
  output logic       READY,
  output logic       TX,
  output logic       BUSY
);

  localparam logic           STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [2:0]     BIT_LAST  = 3'(DATA_BITS - 1);

  uart_state_e          state;
  logic [DATA_BITS-1:0] shift;
  logic [2:0]           bit_idx;
  logic                 stop_idx;
  logic                 bit_done;
  logic                 accept;

  // Ready in idle, or in the final cycle of the last stop bit for back-to-back frames.
  assign READY  = !RST && ((state == ST_IDLE) ||
                  ((state == ST_STOP) && bit_done && (stop_idx == STOP_LAST)));
  assign accept = VALID && READY;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (accept),
    .enable   (state != ST_IDLE),
    .bit_done (bit_done)
  );

  // TX is updated only at bit boundaries, so it is stable for the whole bit period.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      TX       <= IDLE_LEVEL;
      BUSY     <= 1'b0;
      shift    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else if (accept) begin
      state    <= ST_START;
      TX       <= START_LEVEL;
      BUSY     <= 1'b1;
      shift    <= DATA;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          TX   <= IDLE_LEVEL;
          BUSY <= 1'b0;
        end
        ST_START: begin
          if (bit_done) begin
            state <= ST_DATA;
            TX    <= shift[0];
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            shift <= shift >> 1;
            if (bit_idx == BIT_LAST) begin
              state    <= ST_STOP;
              TX       <= IDLE_LEVEL;
              bit_idx  <= '0;
              stop_idx <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              TX      <= shift[1];
            end
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            if (stop_idx == STOP_LAST) begin
              state <= ST_IDLE;
              BUSY  <= 1'b0;
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          TX    <= IDLE_LEVEL;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one-stop-bit and two-stop-bit instances at 4 clocks per bit.
module tb_uart_tx;

  localparam int CPB = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] data = 8'h00;
  logic       valid1 = 1'b0;
  logic       valid2 = 1'b0;
  logic       ready1, tx1, busy1;
  logic       ready2, tx2, busy2;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
    .CLK(CLK), .RST(RST), .DATA(data), .VALID(valid1),
    .READY(ready1), .TX(tx1), .BUSY(busy1)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .CLK(CLK), .RST(RST), .DATA(data), .VALID(valid2),
    .READY(ready2), .TX(tx2), .BUSY(busy2)
  );

  typedef struct {
    bit         sel;
    logic [7:0] d;
    int         nbits;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Present d, optionally scrambling DATA while READY is low, and return just after the accept edge.
  task automatic accept(input bit sel, input logic [7:0] d, input bit scramble);
    int n;
    logic rdy;
    n = 0;
    @(negedge CLK);
    data = d;
    if (sel) valid2 = 1'b1; else valid1 = 1'b1;
    rdy = sel ? ready2 : ready1;
    while (!rdy && n < 200) begin
      @(negedge CLK);
      if (scramble) data = 8'($urandom);
      rdy = sel ? ready2 : ready1;
      n++;
    end
    if (!rdy) chk("ready timeout", 32'(rdy), 32'd1);
    data = d;
    @(posedge CLK);
  endtask

  task automatic capture(input bit sel, input int nbits, output logic [10:0] got,
                         output int glitch, output int rlow, output int bhi,
                         output logic rlast);
    int ncyc;
    logic t;
    ncyc = nbits * CPB;
    got = '0; glitch = 0; rlow = 0; bhi = 0; rlast = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge CLK);
      if (i == 0) begin
        valid1 = 1'b0;
        valid2 = 1'b0;
      end
      t = sel ? tx2 : tx1;
      if (i % CPB == 0) got[nbits - 1 - i / CPB] = t;
      else if (t !== got[nbits - 1 - i / CPB]) glitch++;
      if (!(sel ? ready2 : ready1)) rlow++;
      if (sel ? busy2 : busy1) bhi++;
      if (i == ncyc - 1) rlast = sel ? ready2 : ready1;
    end
  endtask

  initial begin
    logic [10:0] got;
    logic [19:0] g2;
    int glitch, rlow, bhi, rhi;
    logic rlast;

    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] got;
    logic [19:0] g2;
    int glitch, rlow, bhi, rhi;
    logic rlast;

    // Frames are listed start bit first: start, LSB..MSB, stop(s).
    vecs[0] = '{1'b0, 8'hA5, 10, 11'b00101001011};
    vecs[1] = '{1'b0, 8'h00, 10, 11'b00000000001};
    vecs[2] = '{1'b0, 8'hFF, 10, 11'b00111111111};
    vecs[3] = '{1'b0, 8'h81, 10, 11'b00100000011};
    vecs[4] = '{1'b0, 8'h01, 10, 11'b00100000001};
    vecs[5] = '{1'b0, 8'h80, 10, 11'b00000000011};
    vecs[6] = '{1'b1, 8'h55, 11, 11'b01010101011};
    vecs[7] = '{1'b1, 8'h3C, 11, 11'b00011110011};

    // Reset held with VALID high: nothing may handshake.
    valid1 = 1'b1;
    data   = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("rst tx", 32'(tx1), 32'd1);
      chk("rst ready", 32'(ready1), 32'd0);
      chk("rst busy", 32'(busy1), 32'd0);
    end
    RST    = 1'b0;
    valid1 = 1'b0;
    @(negedge CLK);
    chk("post-rst ready", 32'(ready1), 32'd1);
    chk("post-rst ready2", 32'(ready2), 32'd1);
    repeat (5) @(negedge CLK);
    chk("idle tx", 32'(tx1), 32'd1);
    chk("idle busy", 32'(busy1), 32'd0);

    // Table of single frames from idle.
    for (int k = 0; k < 8; k++) begin
      accept(vecs[k].sel, vecs[k].d, 1'b0);
      capture(vecs[k].sel, vecs[k].nbits, got, glitch, rlow, bhi, rlast);
      chk($sformatf("vec%0d frame", k), 32'(got), 32'(vecs[k].exp));
      chk($sformatf("vec%0d glitch", k), 32'(glitch), 32'd0);
      chk($sformatf("vec%0d ready_low", k), 32'(rlow), 32'(vecs[k].nbits * CPB - 1));
      chk($sformatf("vec%0d ready_last", k), 32'(rlast), 32'd1);
      chk($sformatf("vec%0d busy_cycles", k), 32'(bhi), 32'(vecs[k].nbits * CPB));
      @(negedge CLK);
      chk($sformatf("vec%0d idle busy", k), 32'(vecs[k].sel ? busy2 : busy1), 32'd0);
      chk($sformatf("vec%0d idle tx", k), 32'(vecs[k].sel ? tx2 : tx1), 32'd1);
    end

    // Back-to-back 00 then FF with VALID held: 80 cycles, no gap.
    accept(1'b0, 8'h00, 1'b0);
    g2 = '0; glitch = 0; bhi = 0; rhi = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge CLK);
      if (i == 0) data = 8'hFF;
      if (i == 40) valid1 = 1'b0;
      if (i % CPB == 0) g2[19 - i / CPB] = tx1;
      else if (tx1 !== g2[19 - i / CPB]) glitch++;
      if (busy1) bhi++;
      if (ready1) rhi++;
    end
    chk("b2b frames", 32'(g2), 32'(20'b0000000001_0111111111));
    chk("b2b glitch", 32'(glitch), 32'd0);
    chk("b2b busy_cycles", 32'(bhi), 32'd80);
    chk("b2b ready_cycles", 32'(rhi), 32'd2);
    @(negedge CLK);
    chk("b2b end busy", 32'(busy1), 32'd0);

    // Handshake hold: DATA wanders while READY is low; only the accept-edge value is sent.
    accept(1'b0, 8'h00, 1'b0);
    @(negedge CLK);
    valid1 = 1'b0;
    repeat (18) @(negedge CLK);
    accept(1'b0, 8'h3C, 1'b1);
    capture(1'b0, 10, got, glitch, rlow, bhi, rlast);
    chk("hold frame", 32'(got), 32'(11'b00001111001));
    chk("hold glitch", 32'(glitch), 32'd0);
    @(negedge CLK);

    // Reset during data bit 3 of A5 (bit 3 is 0, so the return to 1 is visible).
    accept(1'b0, 8'hA5, 1'b0);
    @(negedge CLK);
    valid1 = 1'b0;
    repeat (17) @(negedge CLK);
    chk("mid bit3 level", 32'(tx1), 32'd0);
    RST = 1'b1;
    #1;
    chk("mid rst ready", 32'(ready1), 32'd0);
    @(negedge CLK);
    chk("mid rst tx", 32'(tx1), 32'd1);
    chk("mid rst busy", 32'(busy1), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("after rst ready", 32'(ready1), 32'd1);
    chk("after rst tx", 32'(tx1), 32'd1);
    accept(1'b0, 8'h81, 1'b0);
    capture(1'b0, 10, got, glitch, rlow, bhi, rlast);
    chk("after rst frame", 32'(got), 32'(11'b00100000011));
    chk("after rst busy_cycles", 32'(bhi), 32'd40);
    @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_tx
